// File: rtl/switch_pkg.sv
// Shared definitions for the switch input-port arbiter: FSM state
// encoding and the default address/data widths of the switch port.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    localparam int SW_ADDR_W = 8;
    localparam int SW_DATA_W = 16;

endpackage

// File: rtl/switch_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Scans the request
// vector starting at i_ptr, wrapping from N-1 to 0, and returns a one-hot
// grant for the first requester found plus a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    localparam logic [PW:0] NV = (PW+1)'(N);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // First requester at or after the pointer, with wrap-around.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= NV) begin
                w_sum = w_sum - NV;
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/switch_arb.sv
// switch_arb: round-robin arbiter sharing one switch input port among NREQ
// requesters. Grants are combinational; the winning beat is registered
// onto addr/data with vld one cycle later.
// Optional burst locking is built when SWITCH_ARB_LOCK_EN is defined:
// a locked owner keeps the port for up to MAX_BURST beats.
//
// state | meaning
// IDLE  | no grant last cycle
// XFER  | unlocked grant last cycle
// LOCK  | burst owner holds the port
module switch_arb import switch_pkg::*; #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = SW_ADDR_W,
    parameter int DATA_W    = SW_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        data,
    output logic                     vld,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t        r_state;
    logic [PTR_W-1:0]  r_ptr;

    logic [NREQ-1:0]   w_pick;
    logic              w_pick_vld;
    logic              w_any;
    logic [PTR_W-1:0]  w_gidx;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_data_sel;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ-1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick),
        .o_valid (w_pick_vld)
    );

`ifdef SWITCH_ARB_LOCK_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [PTR_W-1:0]  r_owner;
    logic [3:0]        r_cnt;

    // Grant: owner only while locked (and only while it still asks for the
    // lock), otherwise the round-robin pick; nothing during reset.
    always_comb begin
        gnt = '0;
        if (!rstn) begin
            if (r_state == LOCK) begin
                if (req[r_owner] && lock[r_owner]) begin
                    gnt[r_owner] = 1'b1;
                end
            end else if (w_pick_vld) begin
                gnt = w_pick;
            end
        end
    end

    assign busy = (r_state == LOCK);
`else
    logic w_unused_lock;

    assign w_unused_lock = ^lock;

    // Grant: plain per-beat round-robin pick; nothing during reset.
    always_comb begin
        gnt = '0;
        if (!rstn && w_pick_vld) begin
            gnt = w_pick;
        end
    end

    assign busy = 1'b0;
`endif

    // Index and payload of the granted requester.
    always_comb begin
        w_gidx     = '0;
        w_addr_sel = '0;
        w_data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_gidx     = PTR_W'(i);
                w_addr_sel = req_addr[i*ADDR_W +: ADDR_W];
                w_data_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_any = |gnt;

    // FSM, round-robin pointer, burst counter and registered switch outputs.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            vld     <= 1'b0;
            addr    <= '0;
            data    <= '0;
`ifdef SWITCH_ARB_LOCK_EN
            r_owner <= '0;
            r_cnt   <= '0;
`endif
        end else begin
            vld <= w_any;
            if (w_any) begin
                addr <= w_addr_sel;
                data <= w_data_sel;
            end
`ifdef SWITCH_ARB_LOCK_EN
            if (r_state == LOCK) begin
                if (!w_any) begin
                    r_state <= IDLE;
                    r_ptr   <= inc_ptr(r_owner);
                    r_cnt   <= '0;
                end else if (r_cnt == BURST_LAST) begin
                    r_state <= XFER;
                    r_ptr   <= inc_ptr(r_owner);
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else if (w_any) begin
                r_ptr <= inc_ptr(w_gidx);
                if (MAX_BURST > 1 && lock[w_gidx]) begin
                    r_state <= LOCK;
                    r_owner <= w_gidx;
                    r_cnt   <= 4'd1;
                end else begin
                    r_state <= XFER;
                end
            end else begin
                r_state <= IDLE;
            end
`else
            if (w_any) begin
                r_ptr   <= inc_ptr(w_gidx);
                r_state <= XFER;
            end else begin
                r_state <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_switch_arb.sv
// Bench for switch_arb (NREQ=4, ADDR_W=8, DATA_W=16, MAX_BURST=4).
// A per-cycle reference model checks every output; directed sequences add
// hand-computed expectations. Burst expectations follow SWITCH_ARB_LOCK_EN.
module tb_switch_arb;

    localparam int N  = 4;
    localparam int MB = 4;
`ifdef SWITCH_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        vld;
    logic        busy;

    int n_pass = 0;
    int n_tot  = 0;

    int          m_ptr = 0;
    int          m_owner = -1;
    int          m_cnt = 0;
    bit          m_vld = 0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    bit          m_started = 0;

    switch_arb #(
        .NREQ      (N),
        .ADDR_W    (8),
        .DATA_W    (16),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .addr     (addr),
        .data     (data),
        .vld      (vld),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected grant from the arbitration rules and current inputs.
    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = '0;
        if (rstn) return g;
        if (LOCK_EN && m_owner >= 0) begin
            if (req[m_owner] && lock[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Model state advance at each rising edge.
    always @(posedge clk) begin
        logic [3:0] g;
        int idx;
        g = model_gnt();
        idx = 0;
        for (int i = 0; i < N; i++) if (g[i]) idx = i;
        if (rstn) begin
            m_ptr = 0; m_owner = -1; m_cnt = 0;
            m_vld = 0; m_addr = '0; m_data = '0;
            m_started = 1;
        end else begin
            m_vld = (g != 0);
            if (g != 0) begin
                m_addr = req_addr[idx*8 +: 8];
                m_data = req_data[idx*16 +: 16];
            end
            if (LOCK_EN && m_owner >= 0) begin
                if (g != 0) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == MB) begin
                        m_ptr = (m_owner + 1) % N;
                        m_owner = -1;
                        m_cnt = 0;
                    end
                end else begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt = 0;
                end
            end else if (g != 0) begin
                m_ptr = (idx + 1) % N;
                if (LOCK_EN && MB > 1 && lock[idx]) begin
                    m_owner = idx;
                    m_cnt = 1;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (m_started) begin
            chk("gnt", 32'(gnt), 32'(model_gnt()));
            chk("vld", 32'(vld), 32'(m_vld));
            chk("addr", 32'(addr), 32'(m_addr));
            chk("data", 32'(data), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tv_req  [12] = '{4'b1111, 4'b1010, 4'b0011, 4'b1001, 4'b1111, 4'b0000,
                                 4'b0100, 4'b1110, 4'b1111, 4'b0001, 4'b1100, 4'b1011};
    logic [3:0] tv_lock [12] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000,
                                 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b0000};

    initial begin
        rstn     = 1'b1;
        req      = 4'b1111;
        lock     = 4'b0000;
        req_addr = {8'hA5, 8'h12, 8'h11, 8'h10};
        req_data = {16'h1234, 16'h2222, 16'h1111, 16'h0F0F};

        // Reset with all requesting.
        tick();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        tick();
        rstn = 1'b0;

        // Fairness: 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("fair_gnt", 32'(gnt), 32'(4'b0001 << (j % 4)));
            chk("fair_vld", 32'(vld), 32'(j != 0));
            tick();
        end

        // Wrap from pointer 3.
        req = 4'b0100;
        @(negedge clk); chk("wrap_pre", 32'(gnt), 32'h4);
        tick();
        req = 4'b0101;
        @(negedge clk); chk("wrap_first", 32'(gnt), 32'h1);
        tick();
        @(negedge clk); chk("wrap_second", 32'(gnt), 32'h4);
        tick();

        // No grant: vld drops, addr holds.
        req = 4'b0000;
        @(negedge clk); chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        @(negedge clk);
        chk("idle_vld", 32'(vld), 32'h0);
        chk("idle_addr_hold", 32'(addr), 32'h12);
        tick();

        // Data path from requester 3.
        req = 4'b1000;
        @(negedge clk); chk("dp_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'b0000;
        @(negedge clk);
        chk("dp_vld", 32'(vld), 32'h1);
        chk("dp_addr", 32'(addr), 32'hA5);
        chk("dp_data", 32'(data), 32'h1234);
        tick();

        // Burst by requester 1 while 2 waits.
        req = 4'b0110; lock = 4'b0010;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
            chk("burst_gnt", 32'(gnt), (b < 4) ? 32'h2 : 32'h4);
            chk("burst_busy", 32'(busy), 32'(b >= 1 && b <= 3));
`else
            chk("rr_gnt", 32'(gnt), (b % 2 == 0) ? 32'h2 : 32'h4);
            chk("rr_busy", 32'(busy), 32'h0);
`endif
            tick();
        end
        req = 4'b0000; lock = 4'b0000;
        tick();

        // Early release: lock drops after two beats.
        req = 4'b0110; lock = 4'b0010;
        @(negedge clk);
        tick();
        @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
        chk("early_beat2", 32'(gnt), 32'h2);
`endif
        tick();
        lock = 4'b0000;
        @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
        chk("early_exit_gnt", 32'(gnt), 32'h0);
`endif
        tick();
        @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
        chk("early_next", 32'(gnt), 32'h4);
        chk("early_busy", 32'(busy), 32'h0);
`endif
        tick();
        req = 4'b0000;
        tick();

        // Owner drops req with lock held.
        req = 4'b0110; lock = 4'b0010;
        @(negedge clk);
        tick();
        req = 4'b0100;
        @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
        chk("rel_gnt", 32'(gnt), 32'h0);
        chk("rel_busy", 32'(busy), 32'h1);
`endif
        tick();
        @(negedge clk);
`ifdef SWITCH_ARB_LOCK_EN
        chk("rel_next", 32'(gnt), 32'h4);
`endif
        tick();
        req = 4'b0000; lock = 4'b0000;
        tick();

        // Reset in the middle of a burst.
        req = 4'b0110; lock = 4'b0010;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk); chk("midrst_gnt", 32'(gnt), 32'h0);
        tick();
        rstn = 1'b0; lock = 4'b0000;
        @(negedge clk);
        chk("midrst_after", 32'(gnt), 32'h2);
        chk("midrst_busy", 32'(busy), 32'h0);
        tick();

        // Mixed request/lock patterns, model-checked.
        for (int v = 0; v < 12; v++) begin
            req  = tv_req[v];
            lock = tv_lock[v];
            req_data[15:0] = 16'(16'hC000 + v);
            tick();
        end
        req = 4'b0000; lock = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/switch_arb.md
SWITCH_ARB -- requirements
Module: switch_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the switch input port (2..8).
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width forwarded to the switch.
REQ-003 Parameter DATA_W, default 16, SHALL set the data width forwarded to the switch.
REQ-004 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive beats per locked grant (1..15).
REQ-005 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 rstn  input  1  SHALL be the synchronous, active-high reset.
REQ-007 req  input  NREQ  SHALL be the per-requester request; requester holds req_addr/req_data stable until granted.
REQ-008 lock  input  NREQ  SHALL be the per-requester burst-hold request, sampled with req.
REQ-009 req_addr  input  NREQ*ADDR_W  SHALL carry the packed requester addresses; slice i belongs to requester i.
REQ-010 req_data  input  NREQ*DATA_W  SHALL carry the packed requester data; slice i belongs to requester i.
REQ-011 gnt  output  NREQ  SHALL be the one-hot, one-cycle acceptance pulse; the beat is consumed in the cycle gnt[i]=1.
REQ-012 addr  output  ADDR_W  SHALL be the registered address driven to the switch.
REQ-013 data  output  DATA_W  SHALL be the registered data driven to the switch.
REQ-014 vld  output  1  SHALL qualify addr/data to the switch.
REQ-015 busy  output  1  SHALL be 1 while the FSM is in LOCK.

Function
REQ-016 gnt SHALL be combinational from req, state and pointer, and SHALL be zero-hot or one-hot at all times.
REQ-017 In the cycle gnt[i]=1, addr/data SHALL capture slice i and vld SHALL be 1 the following cycle (latency 1).
REQ-018 With no grant in a cycle, vld SHALL be 0 the following cycle; addr/data SHALL hold their last value.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps from NREQ-1 to 0; after a grant to i, rr_ptr SHALL become (i+1) mod NREQ.
REQ-020 Throughput SHALL be one beat per cycle with back-to-back grants to different or the same requester.
REQ-021 FSM states SHALL be IDLE (no grant last cycle), XFER (unlocked grant last cycle), LOCK (burst owner held).
REQ-022 IDLE/XFER -> XFER on any unlocked grant; -> LOCK on a grant with lock[i]=1 (feature enabled, MAX_BURST>1); -> IDLE on no grant.
REQ-023 In LOCK, only the owner SHALL be granted; beat counter increments per grant; rr_ptr SHALL not move until exit.
REQ-024 LOCK SHALL exit on the grant that makes the count MAX_BURST, on owner dropping lock, or on owner dropping req; exit goes to XFER if that cycle granted, else IDLE, and rr_ptr becomes owner+1.
REQ-025 Owner with lock=1 and req=0 for one cycle SHALL release LOCK with no grant that cycle and no bubble penalty to others next cycle.
REQ-026 Simultaneous requests with rr_ptr pointing at an idle requester SHALL grant the next requesting index upward with wrap.

Reset
REQ-027 While rstn=1 at a clock edge: vld=0, addr=0, data=0, busy=0, state=IDLE, rr_ptr=0, beat counter=0.
REQ-028 gnt SHALL be forced to 0 while rstn=1; reset mid-burst SHALL drop the burst with no further beats.

Configuration
REQ-029 Macro SWITCH_ARB_LOCK_EN defined SHALL enable LOCK state and burst counter per REQ-022..REQ-025.
REQ-030 Without SWITCH_ARB_LOCK_EN, lock SHALL be ignored, LOCK unreachable, busy tied 0, pure per-beat round-robin.

Structure
REQ-031 Package switch_pkg SHALL hold the FSM state enum (IDLE, XFER, LOCK) and default ADDR_W/DATA_W constants shared with the switch.
REQ-032 Sub-module rr_pick SHALL implement the combinational rotating-priority one-hot picker (req, ptr -> one-hot, valid).

Verification
REQ-033 Reset: rstn=1 two cycles with req=4'b1111 -> gnt=0, vld=0, addr=0, data=0.
REQ-034 Fairness: req=4'b1111 held 8 cycles, lock=0 -> gnt sequence 0,1,2,3,0,1,2,3; vld=1 from cycle 2.
REQ-035 Wrap: rr_ptr=3, req=4'b0101 -> gnt[0] first, then gnt[2].
REQ-036 Burst (LOCK_EN, MAX_BURST=4): req[1]=lock[1]=1, req[2]=1 -> four gnt[1] beats, busy=1, then gnt[2].
REQ-037 Early release: lock[1] drops after beat 2 -> LOCK exit, next grant to requester 2, busy=0.
REQ-038 Data path: req[3]=1, req_addr slice 3=8'hA5, req_data slice 3=16'h1234 -> next cycle vld=1, addr=8'hA5, data=16'h1234.
